banco_registradores_pc: RTL and testbench
=========================================

// Module: banco_registradores_pc
// PURPOSE
//  Storage stage of the register bank: eight LARGURA-bit registers R0..R7.
//  Each register drives its own output, feeding entrada0..entrada7 of the 8:1 read multiplexer directly downstream.
//  R7 doubles as the program counter: it can be loaded like any other register and also incremented in place.
//  One synchronous write port; all reads are combinational.
// PARAMETERS
//  LARGURA         16      data width of every register and of dado_entrada
//  VALOR_RESET_PC  16'h0   value R7 takes on reset
//  PASSO_PC        1       amount added to R7 by incrementa_pc
// PORTS
//  clock             in   1        single clock, rising-edge
//  reset             in   1        asynchronous, active-high
//  dado_entrada      in   LARGURA  write data
//  endereco_escrita  in   3        destination register index 0..7
//  habilita_escrita  in   1        write strobe, sampled on rising clock
//  incrementa_pc     in   1        R7 <= R7 + PASSO_PC, sampled on rising clock
//  saida0..saida7    out  LARGURA  current contents of R0..R7 (to mux entrada0..7)
//  pc_atualizado     out  1        one-cycle pulse: R7 changed on the previous edge
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-high; clock/reset names are as above.
//  - Reset (asserted at any time, including mid-write): effect is immediate, without waiting for an edge.
//    saida0..saida6 = 0, saida7 = VALOR_RESET_PC, pc_atualizado = 0.
//    Any write or increment pending on that edge is discarded.
//  - Reset release: first edge with reset low behaves normally.
//  - Write: on a rising edge with habilita_escrita=1, R[endereco_escrita] <= dado_entrada.
//    The new value appears on saidaN after that edge (1-cycle latency). No write-to-read bypass.
//  - habilita_escrita=0: no register changes except R7 via incrementa_pc.
//  - Increment: on a rising edge with incrementa_pc=1, R7 <= (R7 + PASSO_PC) mod 2^LARGURA.
//    Wrap-around: 16'hFFFF + 1 -> 16'h0000. No flag or saturation.
//  - Simultaneous events on the same edge:
//    * write to R7 and incrementa_pc: the write wins; R7 <= dado_entrada, increment dropped.
//    * write to Rn (n != 7) and incrementa_pc: both take effect.
//  - pc_atualizado: registered, asserted for exactly one cycle after any edge on which R7 was written or incremented.
//    It is asserted even when the new value equals the old (e.g. rewriting the same data).
//    Back-to-back updates keep it high on consecutive cycles.
//  - Invalid control: X/Z on endereco_escrita while habilita_escrita=1 is a bench error (assertion), not a design case.
//    RTL writes no register in that case.
// STRUCTURE
//  - Shared package/header:
//    * LARGURA_PALAVRA = 16, NUM_REGISTRADORES = 8, INDICE_PC = 3'b111.
//    * These are the same constants the read multiplexer uses for width and select.
//  - Sub-module registrador: LARGURA-bit D register with load enable and async active-high reset to a parameter value.
//    Instantiated 8x; R7 gets VALOR_RESET_PC.
//  - Write decode (3->8 one-hot gated by habilita_escrita) is inline.
//  - R7 next-value mux (load / increment / hold) is inline.
// TESTING
//  1. Reset: hold reset 3 cycles with habilita_escrita=1, dado=16'hBEEF -> all saida0..6 = 0, saida7 = VALOR_RESET_PC, pc_atualizado=0.
//  2. Write sweep: write 16'h1111*n to Rn for n=0..6, one per cycle.
//     Each saidaN changes only on its edge; other outputs are stable.
//     The 8:1 mux with select n returns 16'h1111*n.
//  3. PC wrap: write R7=16'hFFFE, then incrementa_pc for 3 cycles.
//     R7 sequence is FFFE -> FFFF -> 0000 -> 0001; pc_atualizado is high on 4 consecutive cycles.
//  4. Collision: on the same edge write R7=16'h0040 and incrementa_pc=1 -> R7=16'h0040.
//     Next edge: write R3=16'hA5A5 with incrementa_pc=1 -> R3=A5A5 and R7=16'h0041.
//  5. Async reset mid-operation: assert reset between edges while a write to R2 is set up -> outputs clear immediately.
//     R2 stays 0 after the edge.
//     Deassert reset -> the next write to R2 succeeds.

Source files
------------

// File: rtl/banco_registradores_pc_pkg.sv
// Shared constants for the register bank and its downstream 8:1 read multiplexer.
// Both blocks take their word width and select width from here so they cannot drift apart.
package banco_registradores_pc_pkg;

    localparam int unsigned LARGURA_PALAVRA   = 16;
    localparam int unsigned NUM_REGISTRADORES = 8;
    localparam int unsigned LARGURA_ENDERECO  = $clog2(NUM_REGISTRADORES);

    // R7 is the program counter.
    localparam logic [LARGURA_ENDERECO-1:0] INDICE_PC = 3'b111;

endpackage

// File: rtl/banco_registradores_pc_registrador.sv
// registrador: LARGURA-bit D register with load enable and asynchronous active-high reset.
// Ports:
//   clock_i   rising-edge clock
//   reset_i   asynchronous reset, active-high; loads VALOR_RESET
//   carrega_i load enable, sampled on the rising edge
//   d_i       data loaded when carrega_i=1
//   q_o       current contents
module registrador #(
    parameter int unsigned         LARGURA     = 16,
    parameter logic [LARGURA-1:0]  VALOR_RESET = '0
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               carrega_i,
    input  logic [LARGURA-1:0] d_i,
    output logic [LARGURA-1:0] q_o
);

    logic [LARGURA-1:0] valor_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valor_q <= VALOR_RESET;
        end else if (carrega_i) begin
            valor_q <= d_i;
        end
    end

    assign q_o = valor_q;

endmodule

// File: rtl/banco_registradores_pc.sv
// banco_registradores_pc: storage stage of the register bank, eight registers R0..R7.
// R7 is also the program counter and can be incremented in place.
// Ports:
//   clock             rising-edge clock
//   reset             asynchronous, active-high; R0..R6 <- 0, R7 <- VALOR_RESET_PC
//   dado_entrada      write data
//   endereco_escrita  destination register index 0..7
//   habilita_escrita  write strobe
//   incrementa_pc     R7 <= R7 + PASSO_PC (a write to R7 on the same edge wins)
//   saida0..saida7    current contents of R0..R7
//   pc_atualizado     one-cycle pulse after any edge that wrote or incremented R7
module banco_registradores_pc
    import banco_registradores_pc_pkg::*;
#(
    parameter int unsigned        LARGURA        = LARGURA_PALAVRA,
    parameter logic [LARGURA-1:0] VALOR_RESET_PC = '0,
    parameter int unsigned        PASSO_PC       = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [LARGURA-1:0]          dado_entrada,
    input  logic [LARGURA_ENDERECO-1:0] endereco_escrita,
    input  logic                        habilita_escrita,
    input  logic                        incrementa_pc,
    output logic [LARGURA-1:0]          saida0,
    output logic [LARGURA-1:0]          saida1,
    output logic [LARGURA-1:0]          saida2,
    output logic [LARGURA-1:0]          saida3,
    output logic [LARGURA-1:0]          saida4,
    output logic [LARGURA-1:0]          saida5,
    output logic [LARGURA-1:0]          saida6,
    output logic [LARGURA-1:0]          saida7,
    output logic                        pc_atualizado
);

    logic [NUM_REGISTRADORES-1:0] escreve;
    logic [LARGURA-1:0]           valor [NUM_REGISTRADORES];
    logic [LARGURA-1:0]           pc_d;
    logic                         carrega_pc;
    logic                         pc_atualizado_q;
    logic                         pc_atualizado_d;

    // One-hot write decode; an unknown address matches no item and writes nothing.
    always_comb begin
        escreve = '0;
        if (habilita_escrita) begin
            case (endereco_escrita)
                3'd0:    escreve = 8'b0000_0001;
                3'd1:    escreve = 8'b0000_0010;
                3'd2:    escreve = 8'b0000_0100;
                3'd3:    escreve = 8'b0000_1000;
                3'd4:    escreve = 8'b0001_0000;
                3'd5:    escreve = 8'b0010_0000;
                3'd6:    escreve = 8'b0100_0000;
                3'd7:    escreve = 8'b1000_0000;
                default: escreve = '0;
            endcase
        end
    end

    // R7 next value: an explicit write takes priority over the increment.
    always_comb begin
        carrega_pc      = escreve[INDICE_PC] | incrementa_pc;
        pc_atualizado_d = carrega_pc;
        if (escreve[INDICE_PC]) begin
            pc_d = dado_entrada;
        end else begin
            pc_d = valor[INDICE_PC] + LARGURA'(PASSO_PC);
        end
    end

    for (genvar i = 0; i < NUM_REGISTRADORES - 1; i++) begin : g_gerais
        registrador #(
            .LARGURA     (LARGURA),
            .VALOR_RESET ('0)
        ) u_reg (
            .clock_i   (clock),
            .reset_i   (reset),
            .carrega_i (escreve[i]),
            .d_i       (dado_entrada),
            .q_o       (valor[i])
        );
    end

    registrador #(
        .LARGURA     (LARGURA),
        .VALOR_RESET (VALOR_RESET_PC)
    ) u_pc (
        .clock_i   (clock),
        .reset_i   (reset),
        .carrega_i (carrega_pc),
        .d_i       (pc_d),
        .q_o       (valor[INDICE_PC])
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_atualizado_q <= 1'b0;
        end else begin
            pc_atualizado_q <= pc_atualizado_d;
        end
    end

    assign saida0        = valor[0];
    assign saida1        = valor[1];
    assign saida2        = valor[2];
    assign saida3        = valor[3];
    assign saida4        = valor[4];
    assign saida5        = valor[5];
    assign saida6        = valor[6];
    assign saida7        = valor[7];
    assign pc_atualizado = pc_atualizado_q;

endmodule

// File: tb/tb_banco_registradores_pc.sv
module tb_banco_registradores_pc;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] dado_entrada;
    logic [2:0]  endereco_escrita;
    logic        habilita_escrita;
    logic        incrementa_pc;
    logic [15:0] saida [8];
    logic        pc_atualizado;

    int total  = 0;
    int passou = 0;

    banco_registradores_pc dut (
        .clock            (clock),
        .reset            (reset),
        .dado_entrada     (dado_entrada),
        .endereco_escrita (endereco_escrita),
        .habilita_escrita (habilita_escrita),
        .incrementa_pc    (incrementa_pc),
        .saida0           (saida[0]),
        .saida1           (saida[1]),
        .saida2           (saida[2]),
        .saida3           (saida[3]),
        .saida4           (saida[4]),
        .saida5           (saida[5]),
        .saida6           (saida[6]),
        .saida7           (saida[7]),
        .pc_atualizado    (pc_atualizado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && habilita_escrita) begin
            assert (!$isunknown(endereco_escrita))
                else $error("unknown endereco_escrita during write");
        end
    end

    typedef struct {
        logic            we;
        logic [2:0]      addr;
        logic [15:0]     dado;
        logic            inc;
        logic [7:0][15:0] exp;
        logic            upd;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nome, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passou++;
        else $display("FAIL %s: got %h expected %h", nome, got, exp);
    endtask

    // Read multiplexer model: select n returns saidaN.
    function automatic logic [15:0] mux8(input logic [2:0] sel);
        return saida[sel];
    endfunction

    task automatic chk_all(input string nome, input logic [7:0][15:0] exp, input logic upd);
        for (int r = 0; r < 8; r++) chk($sformatf("%s saida%0d", nome, r), saida[r], exp[r]);
        chk($sformatf("%s pc_atualizado", nome), {15'b0, pc_atualizado}, {15'b0, upd});
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] addr, input logic [15:0] dado,
                                input logic inc, input logic upd,
                                input logic [15:0] r0, input logic [15:0] r1,
                                input logic [15:0] r2, input logic [15:0] r3,
                                input logic [15:0] r4, input logic [15:0] r5,
                                input logic [15:0] r6, input logic [15:0] r7);
        vec_t v;
        v.we = we; v.addr = addr; v.dado = dado; v.inc = inc; v.upd = upd;
        v.exp = {r7, r6, r5, r4, r3, r2, r1, r0};
        return v;
    endfunction

    logic [7:0][15:0] zeros;
    logic [7:0][15:0] anterior;

    initial begin
        zeros = '0;
        // Write sweep R0..R6.
        vecs[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        vecs[1]  = mk(1, 1, 16'h1111, 0, 0, 16'h0, 16'h1111, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        vecs[2]  = mk(1, 2, 16'h2222, 0, 0, 16'h0, 16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        vecs[3]  = mk(1, 3, 16'h3333, 0, 0, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0, 16'h0, 16'h0);
        vecs[4]  = mk(1, 4, 16'h4444, 0, 0, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0);
        vecs[5]  = mk(1, 5, 16'h5555, 0, 0, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h0, 16'h0);
        vecs[6]  = mk(1, 6, 16'h6666, 0, 0, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h0);
        // PC wrap.
        vecs[7]  = mk(1, 7, 16'hFFFE, 0, 1, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'hFFFE);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 1, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'hFFFF);
        vecs[9]  = mk(0, 0, 16'h0000, 1, 1, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h0000);
        vecs[10] = mk(0, 0, 16'h0000, 1, 1, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h0001);
        vecs[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h0001);
        // Collisions: write to R7 beats increment; write elsewhere coexists with it.
        vecs[12] = mk(1, 7, 16'h0040, 1, 1, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h0040);
        vecs[13] = mk(1, 3, 16'hA5A5, 1, 1, 16'h0, 16'h1111, 16'h2222, 16'hA5A5, 16'h4444, 16'h5555, 16'h6666, 16'h0041);
        // Rewriting the same PC value still pulses pc_atualizado.
        vecs[14] = mk(1, 7, 16'h0041, 0, 1, 16'h0, 16'h1111, 16'h2222, 16'hA5A5, 16'h4444, 16'h5555, 16'h6666, 16'h0041);
        // Strobe low: address/data are ignored.
        vecs[15] = mk(0, 2, 16'hDEAD, 0, 0, 16'h0, 16'h1111, 16'h2222, 16'hA5A5, 16'h4444, 16'h5555, 16'h6666, 16'h0041);
        vecs[16] = mk(0, 0, 16'h0000, 0, 0, 16'h0, 16'h1111, 16'h2222, 16'hA5A5, 16'h4444, 16'h5555, 16'h6666, 16'h0041);

        // Reset held for 3 cycles with a write pending.
        reset            = 1'b1;
        habilita_escrita = 1'b1;
        dado_entrada     = 16'hBEEF;
        endereco_escrita = 3'd7;
        incrementa_pc    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            endereco_escrita = 3'(c + 5);
            @(posedge clock);
            #1;
            chk_all($sformatf("reset ciclo%0d", c), zeros, 1'b0);
        end
        @(negedge clock);
        reset            = 1'b0;
        habilita_escrita = 1'b0;
        incrementa_pc    = 1'b0;

        anterior = zeros;
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            habilita_escrita = vecs[i].we;
            endereco_escrita = vecs[i].addr;
            dado_entrada     = vecs[i].dado;
            incrementa_pc    = vecs[i].inc;
            #1;
            // No bypass: the target still holds its old value before the edge.
            chk($sformatf("vec%0d pre-edge saida%0d", i, vecs[i].addr),
                saida[vecs[i].addr], anterior[vecs[i].addr]);
            @(posedge clock);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].exp, vecs[i].upd);
            if (i < 7) chk($sformatf("vec%0d mux sel%0d", i, i), mux8(3'(i)), vecs[i].dado);
            anterior = vecs[i].exp;
        end

        // Async reset between edges with a write to R2 set up.
        @(negedge clock);
        habilita_escrita = 1'b1;
        endereco_escrita = 3'd2;
        dado_entrada     = 16'h1234;
        incrementa_pc    = 1'b1;
        #1;
        chk("pre-reset saida3", saida[3], 16'hA5A5);
        #1;
        reset = 1'b1;
        #1;
        chk_all("reset imediato", zeros, 1'b0);
        @(posedge clock);
        #1;
        chk_all("reset na borda", zeros, 1'b0);
        @(negedge clock);
        reset         = 1'b0;
        incrementa_pc = 1'b0;
        @(posedge clock);
        #1;
        chk("pos-reset saida2", saida[2], 16'h1234);
        chk("pos-reset saida7", saida[7], 16'h0000);
        chk("pos-reset saida3", saida[3], 16'h0000);
        chk("pos-reset pc_atualizado", {15'b0, pc_atualizado}, 16'h0000);
        @(negedge clock);
        habilita_escrita = 1'b0;

        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end

endmodule
